// File: rtl/alu_mc.sv
// alu_mc: multi-cycle ALU with registered result/flags, a valid/ready input
// handshake and an iterative shift-add multiplier for MUL.
module alu_mc #(
    parameter int N     = 16,
    parameter int CNT_W = 5
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [N-1:0] inp1,
    input  logic [N-1:0] inp2,
    input  logic [2:0]   func,
    output logic [N-1:0] out,
    output logic         out_valid,
    output logic         zero,
    output logic         carry,
    output logic         neg,
    output logic         ovf
);

    typedef enum logic [0:0] {
        IDLE = 1'b0,
        BUSY = 1'b1
    } state_t;

    localparam logic [2:0] F_MOV = 3'b000;
    localparam logic [2:0] F_ADD = 3'b001;
    localparam logic [2:0] F_SUB = 3'b010;
    localparam logic [2:0] F_AND = 3'b011;
    localparam logic [2:0] F_OR  = 3'b100;
    localparam logic [2:0] F_NOT = 3'b101;
    localparam logic [2:0] F_NOP = 3'b110;
    localparam logic [2:0] F_MUL = 3'b111;

    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(N - 1);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

    state_t           state_q, state_d;
    logic [2*N-1:0]   mcand_q, mcand_d;
    logic [2*N-1:0]   acc_q, acc_d;
    logic [N-1:0]     mplier_q, mplier_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [N-1:0]     out_q, out_d;
    logic             zero_q, zero_d;
    logic             carry_q, carry_d;
    logic             neg_q, neg_d;
    logic             ovf_q, ovf_d;
    logic             out_valid_q, out_valid_d;
    logic             in_ready_q, in_ready_d;

    logic [N:0]       sum_s;
    logic [N:0]       diff_s;
    logic [2*N-1:0]   acc_step_s;

    // State, multiplier datapath and result/flag registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            mcand_q     <= {(2*N){1'b0}};
            acc_q       <= {(2*N){1'b0}};
            mplier_q    <= {N{1'b0}};
            cnt_q       <= {CNT_W{1'b0}};
            out_q       <= {N{1'b0}};
            zero_q      <= 1'b1;
            carry_q     <= 1'b0;
            neg_q       <= 1'b0;
            ovf_q       <= 1'b0;
            out_valid_q <= 1'b0;
            in_ready_q  <= 1'b1;
        end else begin
            state_q     <= state_d;
            mcand_q     <= mcand_d;
            acc_q       <= acc_d;
            mplier_q    <= mplier_d;
            cnt_q       <= cnt_d;
            out_q       <= out_d;
            zero_q      <= zero_d;
            carry_q     <= carry_d;
            neg_q       <= neg_d;
            ovf_q       <= ovf_d;
            out_valid_q <= out_valid_d;
            in_ready_q  <= in_ready_d;
        end
    end

    // Next-state, single-cycle ops and one shift-add multiplier step.
    always_comb begin
        state_d     = state_q;
        mcand_d     = mcand_q;
        acc_d       = acc_q;
        mplier_d    = mplier_q;
        cnt_d       = cnt_q;
        out_d       = out_q;
        carry_d     = carry_q;
        ovf_d       = ovf_q;
        out_valid_d = 1'b0;
        in_ready_d  = in_ready_q;

        sum_s      = {1'b0, inp1} + {1'b0, inp2};
        diff_s     = {1'b0, inp1} - {1'b0, inp2};
        acc_step_s = acc_q + (mplier_q[0] ? mcand_q : {(2*N){1'b0}});

        case (state_q)
            IDLE: begin
                if (in_valid) begin
                    if (func == F_MUL) begin
                        state_d    = BUSY;
                        mcand_d    = {{N{1'b0}}, inp1};
                        mplier_d   = inp2;
                        acc_d      = {(2*N){1'b0}};
                        cnt_d      = {CNT_W{1'b0}};
                        in_ready_d = 1'b0;
                    end else begin
                        out_valid_d = 1'b1;
                        case (func)
                            F_MOV: begin out_d = inp2;        carry_d = 1'b0; ovf_d = 1'b0; end
                            F_ADD: begin
                                out_d   = sum_s[N-1:0];
                                carry_d = sum_s[N];
                                ovf_d   = (inp1[N-1] == inp2[N-1]) & (sum_s[N-1] != inp1[N-1]);
                            end
                            F_SUB: begin
                                // diff_s[N] is the borrow, i.e. inp1 < inp2 unsigned
                                out_d   = diff_s[N-1:0];
                                carry_d = diff_s[N];
                                ovf_d   = (inp1[N-1] != inp2[N-1]) & (diff_s[N-1] != inp1[N-1]);
                            end
                            F_AND: begin out_d = inp1 & inp2; carry_d = 1'b0; ovf_d = 1'b0; end
                            F_OR:  begin out_d = inp1 | inp2; carry_d = 1'b0; ovf_d = 1'b0; end
                            F_NOT: begin out_d = ~inp2;       carry_d = 1'b0; ovf_d = 1'b0; end
                            F_NOP: begin out_d = out_q;       carry_d = carry_q; ovf_d = ovf_q; end
                            default: begin out_d = out_q;     carry_d = carry_q; ovf_d = ovf_q; end
                        endcase
                    end
                end else begin
                    state_d = IDLE;
                end
            end
            BUSY: begin
                acc_d    = acc_step_s;
                mcand_d  = mcand_q << 1;
                mplier_d = mplier_q >> 1;
                cnt_d    = cnt_q + CNT_ONE;
                if (cnt_q == CNT_LAST) begin
                    state_d     = IDLE;
                    in_ready_d  = 1'b1;
                    out_valid_d = 1'b1;
                    out_d       = acc_step_s[N-1:0];
                    carry_d     = |acc_step_s[2*N-1:N];
                    ovf_d       = 1'b0;
                end else begin
                    state_d = BUSY;
                end
            end
            default: begin
                state_d    = IDLE;
                in_ready_d = 1'b1;
            end
        endcase

        // zero/neg always follow the value out will hold after this edge
        zero_d = (out_d == {N{1'b0}});
        neg_d  = out_d[N-1];
    end

    assign out       = out_q;
    assign zero      = zero_q;
    assign carry     = carry_q;
    assign neg       = neg_q;
    assign ovf       = ovf_q;
    assign out_valid = out_valid_q;
    assign in_ready  = in_ready_q;

endmodule

// File: tb/tb_alu_mc.sv
// tb_alu_mc: directed test of alu_mc with an arithmetic reference model
// compared every cycle, plus hand-computed literal expectations.
module tb_alu_mc;
    localparam int N = 16;

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic         in_valid = 1'b0;
    logic [N-1:0] inp1 = '0;
    logic [N-1:0] inp2 = '0;
    logic [2:0]   func = 3'b000;
    logic         in_ready;
    logic [N-1:0] out;
    logic         out_valid, zero, carry, neg, ovf;

    int checks = 0;
    int failures = 0;

    always #5 clk = ~clk;

    alu_mc #(.N(N), .CNT_W(5)) dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
        .inp1(inp1), .inp2(inp2), .func(func), .out(out), .out_valid(out_valid),
        .zero(zero), .carry(carry), .neg(neg), .ovf(ovf)
    );

    // Reference model state
    logic [15:0] m_out, ma, mb;
    logic        m_zero, m_carry, m_neg, m_ovf, m_valid, m_ready;
    int          busy_left;
    int unsigned p;
    int          s;

    always @(posedge clk) begin
        if (!rst_n) begin
            m_out = 16'h0; m_zero = 1'b1; m_carry = 1'b0; m_neg = 1'b0; m_ovf = 1'b0;
            m_valid = 1'b0; m_ready = 1'b1; busy_left = 0;
        end else begin
            m_valid = 1'b0;
            if (busy_left > 0) begin
                busy_left--;
                if (busy_left == 0) begin
                    p = ma * mb;
                    m_out = p[15:0]; m_carry = (p >> 16) != 0; m_ovf = 1'b0;
                    m_valid = 1'b1; m_ready = 1'b1;
                end
            end else if (in_valid) begin
                m_valid = 1'b1;
                case (func)
                    3'd0: begin m_out = inp2; m_carry = 1'b0; m_ovf = 1'b0; end
                    3'd1: begin
                        p = inp1 + inp2;
                        s = $signed(inp1) + $signed(inp2);
                        m_out = p[15:0]; m_carry = p > 32'hFFFF;
                        m_ovf = (s > 32767) || (s < -32768);
                    end
                    3'd2: begin
                        s = $signed(inp1) - $signed(inp2);
                        m_out = inp1 - inp2; m_carry = inp1 < inp2;
                        m_ovf = (s > 32767) || (s < -32768);
                    end
                    3'd3: begin m_out = inp1 & inp2; m_carry = 1'b0; m_ovf = 1'b0; end
                    3'd4: begin m_out = inp1 | inp2; m_carry = 1'b0; m_ovf = 1'b0; end
                    3'd5: begin m_out = ~inp2; m_carry = 1'b0; m_ovf = 1'b0; end
                    3'd6: begin end
                    default: begin
                        busy_left = N; ma = inp1; mb = inp2;
                        m_ready = 1'b0; m_valid = 1'b0;
                    end
                endcase
            end
            m_zero = (m_out == 16'h0);
            m_neg  = m_out[15];
        end
        #1;
        checks++;
        if ({out_valid, in_ready} !== {m_valid, m_ready}) begin
            failures++;
            $display("FAIL cyc_hs t=%0t got valid/ready=%b%b exp=%b%b", $time,
                     out_valid, in_ready, m_valid, m_ready);
        end
        checks++;
        if ({out, zero, carry, neg, ovf} !== {m_out, m_zero, m_carry, m_neg, m_ovf}) begin
            failures++;
            $display("FAIL cyc_res t=%0t got out=%h zcno=%b%b%b%b exp out=%h zcno=%b%b%b%b",
                     $time, out, zero, carry, neg, ovf, m_out, m_zero, m_carry, m_neg, m_ovf);
        end
    end

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%h exp=%h", name, got, exp);
        end
    endtask

    // Present one op for one cycle; returns at the negedge after the accept edge.
    task automatic do_op(input logic [2:0] f, input logic [15:0] a, input logic [15:0] b);
        @(negedge clk);
        in_valid = 1'b1; func = f; inp1 = a; inp2 = b;
        @(negedge clk);
        in_valid = 1'b0;
    endtask

    // Called right after a MUL accept; holds a junk ADD on the inputs while busy.
    task automatic mul_wait(output int lat, output int lowcnt);
        int k;
        lowcnt = in_ready ? 0 : 1;
        in_valid = 1'b1; func = 3'd1; inp1 = 16'hAAAA; inp2 = 16'h5555;
        for (k = 1; k <= 40; k++) begin
            @(negedge clk);
            if (out_valid) break;
            if (!in_ready) lowcnt++;
        end
        in_valid = 1'b0;
        lat = k;
    endtask

    task automatic chk_reset(input string name);
        chk({name, "_out"}, out, 32'h0);
        chk({name, "_flags"}, {zero, carry, neg, ovf}, 32'b1000);
        chk({name, "_hs"}, {out_valid, in_ready}, 32'b01);
    endtask

    int lat, lowcnt, seen;

    initial begin
        repeat (3) @(negedge clk);
        chk_reset("reset");
        rst_n = 1'b1;

        // 1: ADD wraps to zero with carry
        do_op(3'd1, 16'hFFFF, 16'h0001);
        chk("t1_valid", out_valid, 32'h1);
        chk("t1_out", out, 32'h0);
        chk("t1_flags", {zero, carry, neg, ovf}, 32'b1100);
        do_op(3'd6, 16'h1234, 16'h4321);
        chk("t1_nop_hold", {out, zero, carry}, {16'h0, 2'b11});

        // 2: signed overflow, then SUB with borrow
        do_op(3'd1, 16'h7FFF, 16'h0001);
        chk("t2_add_out", out, 32'h8000);
        chk("t2_add_flags", {zero, carry, neg, ovf}, 32'b0011);
        do_op(3'd2, 16'h0005, 16'h0007);
        chk("t2_sub_out", out, 32'hFFFE);
        chk("t2_sub_flags", {zero, carry, neg, ovf}, 32'b0110);
        do_op(3'd6, 16'h0000, 16'h0000);
        chk("t2_nop_hold", {out, carry, neg}, {16'hFFFE, 2'b11});

        // 3: back-to-back single-cycle ops
        @(negedge clk);
        in_valid = 1'b1; func = 3'd1; inp1 = 16'h0001; inp2 = 16'h0002;
        @(negedge clk);
        chk("t3_add", {out_valid, in_ready, out}, {2'b11, 16'h0003});
        func = 3'd4; inp1 = 16'h00F0; inp2 = 16'h000F;
        @(negedge clk);
        chk("t3_or", {out_valid, in_ready, out}, {2'b11, 16'h00FF});
        func = 3'd5; inp1 = 16'h0000; inp2 = 16'h0000;
        @(negedge clk);
        chk("t3_not", {out_valid, in_ready, out}, {2'b11, 16'hFFFF});
        in_valid = 1'b0;
        @(negedge clk);
        chk("t3_idle", out_valid, 32'h0);

        // 4: multiplies
        do_op(3'd7, 16'h0123, 16'h0045);
        mul_wait(lat, lowcnt);
        chk("t4_latency", lat, 32'd16);
        chk("t4_ready_low", lowcnt, 32'd16);
        chk("t4_out", out, 32'h4E6F);
        chk("t4_carry", carry, 32'h0);
        do_op(3'd7, 16'h0100, 16'h0100);
        mul_wait(lat, lowcnt);
        chk("t4b_latency", lat, 32'd16);
        chk("t4b_res", {out, zero, carry}, {16'h0000, 2'b11});
        do_op(3'd7, 16'hFFFF, 16'hFFFF);
        mul_wait(lat, lowcnt);
        chk("t4c_res", {out, carry, neg}, {16'h0001, 2'b10});

        // 5: NOP holds result and flags
        do_op(3'd1, 16'h0002, 16'h0003);
        chk("t5_add", out, 32'h0005);
        do_op(3'd6, 16'h0000, 16'h0000);
        chk("t5_nop_valid", out_valid, 32'h1);
        chk("t5_nop_hold", {out, zero, carry, neg, ovf}, {16'h0005, 4'b0000});

        // 6: reset in the middle of a MUL
        do_op(3'd7, 16'h1234, 16'h5678);
        repeat (7) @(negedge clk);
        chk("t6_busy", in_ready, 32'h0);
        rst_n = 1'b0;
        @(negedge clk);
        chk_reset("t6_reset");
        @(negedge clk);
        rst_n = 1'b1;
        seen = 0;
        for (int i = 0; i < 24; i++) begin
            @(negedge clk);
            if (out_valid) seen++;
        end
        chk("t6_no_valid", seen, 32'd0);
        do_op(3'd1, 16'h0001, 16'h0001);
        chk("t6_add", {out_valid, out}, {1'b1, 16'h0002});

        repeat (3) @(negedge clk);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
